// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian crossing controller: phase encoding,
// default timing parameters and the vehicle lamp one-hot legality check.
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    localparam int DEBOUNCE_TICKS_DEF = 3;
    localparam int WALK_TICKS_DEF     = 5;
    localparam int CLEAR_TICKS_DEF    = 3;
    localparam int CNT_W_DEF          = 4;

    // True when exactly one vehicle lamp is lit.
    function automatic logic lamp_legal(input logic r, input logic y, input logic g);
        return (r & ~y & ~g) | (~r & y & ~g) | (~r & ~y & g);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, tick-based debounce counter
// and release lock. Emits a single-clock press pulse on the tick where the
// stable-high count reaches DEBOUNCE_TICKS.
module btn_debounce
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic btn,
    output logic press
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEBOUNCE_TICKS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Bring the raw button into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Count stable-high ticks; holding at FULL locks out repeats until release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!sync2) begin
            cnt <= '0;
        end else if (tick && (cnt != FULL)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign press = sync2 & tick & (cnt == LAST);

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller downstream of the vehicle traffic-light FSM.
// Grants WALK only on a vehicle red start edge with a pending request, then a
// flashing clearance phase; aborts to IDLE if red drops or a lamp fault occurs.
// Optional build macro PED_COUNTDOWN_EN drives countdown with the clearance
// counter during CLEAR; otherwise countdown is tied to 0.
module ped_crossing_ctrl
    import ped_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter int WALK_TICKS     = WALK_TICKS_DEF,
    parameter int CLEAR_TICKS    = CLEAR_TICKS_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    output logic             walk,
    output logic             dont_walk,
    output logic [CNT_W-1:0] countdown,
    output logic             req_pending,
    output logic             fault
);

    localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_TICKS);
    localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_TICKS);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             red_q;
    logic             press;
    logic             red_edge;
    logic             fault_next;
    logic             enter_walk;
    logic             abort;

    btn_debounce #(
        .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn   (btn),
        .press (press)
    );

    // A fault seen this clock already blocks entry and forces an abort.
    assign red_edge   = red & ~red_q;
    assign fault_next = fault | ~lamp_legal(red, yellow, green);
    assign enter_walk = (state == IDLE) & red_edge & (req_pending | press) & ~fault_next;
    assign abort      = ~red | fault_next;

    // Red edge history and sticky lamp-legality fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_q <= 1'b0;
            fault <= 1'b0;
        end else begin
            red_q <= red;
            fault <= fault_next;
        end
    end

    // Request latch: a new press wins over the clear on WALK entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_pending <= 1'b0;
        end else begin
            req_pending <= press | (req_pending & ~enter_walk);
        end
    end

    // Crossing phase sequencer with registered lamp and countdown outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
`ifdef PED_COUNTDOWN_EN
            countdown <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (enter_walk) begin
                        state     <= WALK;
                        cnt       <= WALK_LOAD;
                        walk      <= 1'b1;
                        dont_walk <= 1'b0;
                    end
                end
                WALK: begin
                    if (abort) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
                    end else if (tick) begin
                        if (cnt == '0) begin
                            state     <= CLEAR;
                            cnt       <= CLEAR_LOAD;
                            walk      <= 1'b0;
                            dont_walk <= 1'b1;
`ifdef PED_COUNTDOWN_EN
                            countdown <= CLEAR_LOAD;
`endif
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    if (abort || (tick && (cnt == '0))) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        walk      <= 1'b0;
                        dont_walk <= 1'b1;
`ifdef PED_COUNTDOWN_EN
                        countdown <= '0;
`endif
                    end else if (tick) begin
                        cnt       <= cnt - 1'b1;
                        dont_walk <= ~dont_walk;
`ifdef PED_COUNTDOWN_EN
                        countdown <= cnt - 1'b1;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    walk      <= 1'b0;
                    dont_walk <= 1'b1;
                end
            endcase
        end
    end

`ifndef PED_COUNTDOWN_EN
    assign countdown = '0;
`endif

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic checked against a phase-level model.
`timescale 1ns/1ps
module tb_ped_crossing_ctrl;

    localparam int D  = 3;
    localparam int W  = 5;
    localparam int C  = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, tick, btn, red, yellow, green;
    logic          walk, dont_walk, req_pending, fault;
    logic [CW-1:0] countdown;

    int n_checks = 0;
    int n_fail   = 0;

    ped_crossing_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .btn         (btn),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .walk        (walk),
        .dont_walk   (dont_walk),
        .countdown   (countdown),
        .req_pending (req_pending),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Reference model: phase 0 = idle, 1 = walk, 2 = clear; rem = ticks left.
    logic m_s1, m_s2, m_redprev, m_req, m_fault;
    int   m_run, m_phase, m_rem;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_redprev = 0; m_req = 0; m_fault = 0;
        m_run = 0; m_phase = 0; m_rem = 0;
    endtask

    task automatic model_clock(input logic b, input logic r, input logic y,
                               input logic g, input logic t);
        logic pr, redge, fn, enter;
        int   run_n;
        pr = m_s2 && t && (m_run == D - 1);
        if (!m_s2)                 run_n = 0;
        else if (t && m_run < D)   run_n = m_run + 1;
        else                       run_n = m_run;
        redge = r && !m_redprev;
        fn    = m_fault || ((int'(r) + int'(y) + int'(g)) != 1);
        enter = 0;
        if (m_phase == 0) begin
            if (redge && (m_req || pr) && !fn) begin
                m_phase = 1; m_rem = W; enter = 1;
            end
        end else if (!r || fn) begin
            m_phase = 0; m_rem = 0;
        end else if (t) begin
            if (m_rem > 0)          m_rem = m_rem - 1;
            else if (m_phase == 1)  begin m_phase = 2; m_rem = C; end
            else                    m_phase = 0;
        end
        m_req = pr || (m_req && !enter);
        m_s2 = m_s1; m_s1 = b; m_redprev = r; m_fault = fn; m_run = run_n;
    endtask

    function automatic logic [7:0] model_out();
        logic       w, dw;
        logic [3:0] cd;
        w = (m_phase == 1);
        if (m_phase == 0)      dw = 1'b1;
        else if (m_phase == 1) dw = 1'b0;
        else                   dw = (((C - m_rem) % 2) == 0);
        cd = 4'd0;
`ifdef PED_COUNTDOWN_EN
        if (m_phase == 2) cd = 4'(m_rem);
`endif
        return {w, dw, cd, m_req, m_fault};
    endfunction

    function automatic logic [7:0] dut_vec();
        return {walk, dont_walk, countdown, req_pending, fault};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: walk/dont_walk/countdown/req/fault got %b required %b at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic b, input logic r, input logic y,
                        input logic g, input logic t);
        @(negedge clk);
        btn = b; red = r; yellow = y; green = g; tick = t;
        @(posedge clk);
        model_clock(b, r, y, g, t);
        #1 check("model", dut_vec(), model_out());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; btn = 0; red = 1; yellow = 0; green = 0; tick = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset", dut_vec(), 8'b0100_0000);
        rst = 0;
    endtask

    // Three ticks of btn high during green followed by release.
    task automatic press_on_green();
        repeat (3) step(1, 0, 0, 1, 1);
        repeat (4) step(0, 0, 0, 1, 1);
    endtask

    typedef struct packed {
        logic       b, r, g;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic b, input logic r, input logic g, input logic w,
                               input logic dw, input logic [3:0] cd, input logic rq);
        vec_t x;
        x.b = b; x.r = r; x.g = g;
        x.exp = {w, dw, cd, rq, 1'b0};
        return x;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] e;
        logic rb, rt;
        int   idx, dur;

        rst = 1; btn = 0; red = 1; yellow = 0; green = 0; tick = 0;
        model_reset();

        // Main scenario: valid press on green, then a full walk/clear cycle.
        tbl.push_back(v(1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(v(1, 0, 1, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 0));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 1));
        tbl.push_back(v(0, 0, 1, 0, 1, 0, 1));
        tbl.push_back(v(0, 1, 0, 1, 0, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(v(0, 1, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 3, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 2, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 1, 0));
        tbl.push_back(v(0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 0, 1, 0, 0));

        do_reset();
        foreach (tbl[i]) begin
            step(tbl[i].b, tbl[i].r, 0, tbl[i].g, 1);
            e = tbl[i].exp;
`ifndef PED_COUNTDOWN_EN
            e[5:2] = 4'd0;
`endif
            check($sformatf("table[%0d]", i), dut_vec(), e);
        end

        // Bounce: only two ticks high never registers.
        do_reset();
        repeat (2) step(1, 0, 0, 1, 1);
        repeat (4) step(0, 0, 0, 1, 1);
        check_bit("bounce_req", req_pending, 1'b0);
        repeat (3) begin
            step(0, 1, 0, 0, 1);
            check_bit("bounce_walk", walk, 1'b0);
        end

        // Request during WALK is served on the next red start edge only.
        do_reset();
        press_on_green();
        step(0, 1, 0, 0, 1);
        check_bit("req2_walk_first", walk, 1'b1);
        repeat (3) step(1, 1, 0, 0, 1);
        repeat (10) step(0, 1, 0, 0, 1);
        check_bit("req2_pending_idle", req_pending, 1'b1);
        check_bit("req2_no_walk_yet", walk, 1'b0);
        repeat (2) step(0, 0, 0, 1, 1);
        check_bit("req2_no_walk_green", walk, 1'b0);
        step(0, 1, 0, 0, 1);
        check_bit("req2_walk_again", walk, 1'b1);
        check_bit("req2_req_cleared", req_pending, 1'b0);

        // Abort: green mid-WALK drops to IDLE, request not restored.
        do_reset();
        press_on_green();
        step(0, 1, 0, 0, 1);
        repeat (2) step(0, 1, 0, 0, 1);
        step(0, 0, 0, 1, 1);
        check("abort", dut_vec(), 8'b0100_0000);
        step(0, 1, 0, 0, 1);
        check_bit("abort_no_regrant", walk, 1'b0);

        // Asynchronous reset mid-WALK.
        do_reset();
        press_on_green();
        step(0, 1, 0, 0, 1);
        #2 rst = 1;
        #1 check("async_rst", dut_vec(), 8'b0100_0000);
        model_reset();
        @(negedge clk);
        rst = 0;

        // Illegal lamps set a sticky fault that blocks WALK.
        do_reset();
        repeat (2) step(0, 1, 0, 0, 1);
        step(0, 1, 0, 1, 1);
        check_bit("fault_set", fault, 1'b1);
        press_on_green();
        step(0, 1, 0, 0, 1);
        check_bit("fault_no_walk", walk, 1'b0);
        check_bit("fault_sticky", fault, 1'b1);
        do_reset();

        // Randomized traffic with random ticks and button activity.
        idx = 0; dur = 10; rb = 0;
        for (int i = 0; i < 4000; i++) begin
            if (dur == 0) begin
                idx = (idx + 1) % 3;
                dur = $urandom_range(3, 25);
            end
            dur--;
            if ($urandom_range(0, 5) == 0) rb = ~rb;
            rt = ($urandom_range(0, 2) == 0);
            if (i == 3900) begin
                logic [2:0] lmp;
                lmp = 3'($urandom_range(0, 7));
                step(rb, lmp[2], lmp[1], lmp[0], rt);
            end else begin
                step(rb, idx == 2, idx == 1, idx == 0, rt);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
